accumulator_seq_ctrl: RTL and testbench

Sequencer for the accumulator bank in the systolic-array datapath. It accepts a tile job of R output rows and K reduction tiles and steers partial-sum beats from the array into the bank: overwrite on the first K-tile, accumulate on the rest. It then drains the finished rows over a valid/ready stream to the post-processing stage. It owns the bank's `addr`, `wr_en`, `acc_mode` and `in_psum_vec` inputs exclusively.

---
 rtl/accumulator_seq_ctrl.sv | 134 +++++++++++++
 tb/tb_accumulator_seq_ctrl.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/accumulator_seq_ctrl.sv
// Accumulator bank sequencer: steers partial-sum beats into the bank, then drains finished rows.
// Optional macro ACC_CLEAR_ON_DRAIN_EN zeroes each bank row as it is drained.
module accumulator_seq_ctrl #(
    parameter int DEPTH  = 16,
    parameter int ADDR_W = 4,
    parameter int KCNT_W = 8,
    parameter int COL    = 4,
    parameter int ACC_W  = 32
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   cmd_valid,
    output logic                   cmd_ready,
    input  logic [ADDR_W:0]        cmd_rows,
    input  logic [KCNT_W-1:0]      cmd_ktiles,
    input  logic                   psum_valid,
    output logic                   psum_ready,
    input  logic [COL*ACC_W-1:0]   psum_vec,
    output logic [ADDR_W-1:0]      acc_addr,
    output logic                   acc_wr_en,
    output logic                   acc_mode,
    output logic [COL*ACC_W-1:0]   acc_psum_vec,
    input  logic [COL*ACC_W-1:0]   acc_rd_vec,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [COL*ACC_W-1:0]   out_vec,
    output logic                   out_last,
    output logic                   busy,
    output logic                   done
);

    typedef enum logic [1:0] {IDLE, ACCUM, DRAIN} state_t;

    localparam logic [ADDR_W:0] DEPTH_V = (ADDR_W + 1)'(DEPTH);

    state_t              state;
    logic [ADDR_W-1:0]   row_cnt;
    logic [ADDR_W-1:0]   last_row;
    logic [KCNT_W-1:0]   k_cnt;
    logic [KCNT_W-1:0]   last_k;
    logic                done_q;

    logic [ADDR_W:0]     rows_clamped;
    logic [ADDR_W:0]     rows_minus1;
    logic [KCNT_W-1:0]   ktiles_minus1;
    logic                row_end;
    logic                k_end;

    // The job is held as "index of last row / last K-tile" so the FSM only compares.
    always_comb begin
        rows_clamped = cmd_rows;
        if (cmd_rows == '0 || cmd_rows > DEPTH_V)
            rows_clamped = DEPTH_V;
        rows_minus1   = rows_clamped - (ADDR_W + 1)'(1);
        ktiles_minus1 = (cmd_ktiles == '0) ? '0 : cmd_ktiles - KCNT_W'(1);
    end

    assign row_end = (row_cnt == last_row);
    assign k_end   = (k_cnt == last_k);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            row_cnt  <= '0;
            k_cnt    <= '0;
            last_row <= '0;
            last_k   <= '0;
            done_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (cmd_valid) begin
                        last_row <= rows_minus1[ADDR_W-1:0];
                        last_k   <= ktiles_minus1;
                        row_cnt  <= '0;
                        k_cnt    <= '0;
                        state    <= ACCUM;
                    end
                end
                ACCUM: begin
                    if (psum_valid) begin
                        if (row_end) begin
                            row_cnt <= '0;
                            k_cnt   <= k_cnt + KCNT_W'(1);
                            if (k_end)
                                state <= DRAIN;
                        end else begin
                            row_cnt <= row_cnt + ADDR_W'(1);
                        end
                    end
                end
                DRAIN: begin
                    if (out_ready) begin
                        if (row_end) begin
                            row_cnt <= '0;
                            done_q  <= 1'b1;
                            state   <= IDLE;
                        end else begin
                            row_cnt <= row_cnt + ADDR_W'(1);
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Handshake outputs decode from state only, so no path exists from a partner's valid/ready.
    always_comb begin
        cmd_ready    = (state == IDLE);
        psum_ready   = (state == ACCUM);
        out_valid    = (state == DRAIN);
        busy         = (state != IDLE);
        done         = done_q;
        acc_addr     = row_cnt;
        out_vec      = acc_rd_vec;
        out_last     = (state == DRAIN) && row_end;
        acc_wr_en    = 1'b0;
        acc_mode     = 1'b0;
        acc_psum_vec = '0;
        if (state == ACCUM) begin
            acc_wr_en    = psum_valid;
            acc_mode     = (k_cnt != '0);
            acc_psum_vec = psum_vec;
        end
`ifdef ACC_CLEAR_ON_DRAIN_EN
        if (state == DRAIN)
            acc_wr_en = out_ready;
`else
`endif
    end

endmodule

// File: tb/tb_accumulator_seq_ctrl.sv
// Self-checking bench for accumulator_seq_ctrl with a behavioural bank and a per-job row-sum model.
module tb_accumulator_seq_ctrl;

    localparam int DEPTH  = 16;
    localparam int ADDR_W = 4;
    localparam int KCNT_W = 8;
    localparam int COL    = 4;
    localparam int ACC_W  = 32;
    localparam int VW     = COL * ACC_W;
`ifdef ACC_CLEAR_ON_DRAIN_EN
    localparam bit CLEAR = 1'b1;
`else
    localparam bit CLEAR = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              rst;
    logic              cmd_valid;
    logic              cmd_ready;
    logic [ADDR_W:0]   cmd_rows;
    logic [KCNT_W-1:0] cmd_ktiles;
    logic              psum_valid;
    logic              psum_ready;
    logic [VW-1:0]     psum_vec;
    logic [ADDR_W-1:0] acc_addr;
    logic              acc_wr_en;
    logic              acc_mode;
    logic [VW-1:0]     acc_psum_vec;
    logic [VW-1:0]     acc_rd_vec;
    logic              out_valid;
    logic              out_ready;
    logic [VW-1:0]     out_vec;
    logic              out_last;
    logic              busy;
    logic              done;

    int n_checks = 0;
    int n_fail   = 0;

    logic [VW-1:0] bank [DEPTH] = '{default: '0};
    logic [VW-1:0] bank_next;
    logic [VW-1:0] exp_bank [DEPTH] = '{default: '0};
    logic [VW-1:0] beats [$];

    accumulator_seq_ctrl #(
        .DEPTH(DEPTH), .ADDR_W(ADDR_W), .KCNT_W(KCNT_W), .COL(COL), .ACC_W(ACC_W)
    ) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_rows(cmd_rows), .cmd_ktiles(cmd_ktiles),
        .psum_valid(psum_valid), .psum_ready(psum_ready), .psum_vec(psum_vec),
        .acc_addr(acc_addr), .acc_wr_en(acc_wr_en), .acc_mode(acc_mode),
        .acc_psum_vec(acc_psum_vec), .acc_rd_vec(acc_rd_vec),
        .out_valid(out_valid), .out_ready(out_ready), .out_vec(out_vec),
        .out_last(out_last), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    // Accumulator bank: combinational read, per-column overwrite or add on write.
    assign acc_rd_vec = bank[acc_addr];
    always @(posedge clk) begin
        if (acc_wr_en) begin
            for (int c = 0; c < COL; c++)
                bank_next[c*ACC_W +: ACC_W] = acc_mode ?
                    bank[acc_addr][c*ACC_W +: ACC_W] + acc_psum_vec[c*ACC_W +: ACC_W] :
                    acc_psum_vec[c*ACC_W +: ACC_W];
            bank[acc_addr] <= bank_next;
        end
    end

    function automatic logic [VW-1:0] splat(input logic [ACC_W-1:0] v);
        return {COL{v}};
    endfunction

    function automatic logic [VW-1:0] rand_vec();
        logic [VW-1:0] v;
        for (int c = 0; c < COL; c++) v[c*ACC_W +: ACC_W] = $urandom;
        return v;
    endfunction

    function automatic logic [VW-1:0] add_cols(input logic [VW-1:0] a, input logic [VW-1:0] b);
        logic [VW-1:0] s;
        for (int c = 0; c < COL; c++) s[c*ACC_W +: ACC_W] = a[c*ACC_W +: ACC_W] + b[c*ACC_W +: ACC_W];
        return s;
    endfunction

    task automatic check(input string tag, input logic [VW-1:0] obs, input logic [VW-1:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_reset_outputs();
        check("rst_cmd_ready", cmd_ready, 1);
        check("rst_psum_ready", psum_ready, 0);
        check("rst_wr_en", acc_wr_en, 0);
        check("rst_mode", acc_mode, 0);
        check("rst_addr", acc_addr, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_last", out_last, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_psum_vec", acc_psum_vec, 0);
    endtask

    task automatic issue_cmd(input int rows_cmd, input int k_cmd);
        @(negedge clk);
        #1;
        check("cmd_ready_idle", cmd_ready, 1);
        check("busy_idle", busy, 0);
        cmd_valid  = 1'b1;
        cmd_rows   = (ADDR_W + 1)'(rows_cmd);
        cmd_ktiles = KCNT_W'(k_cmd);
        @(posedge clk);
        @(negedge clk);
        cmd_valid = 1'b0;
        #1;
        check("cmd_ready_busy", cmd_ready, 0);
        check("busy_accum", busy, 1);
        check("psum_ready_accum", psum_ready, 1);
        check("no_beat_wr_en", acc_wr_en, 0);
        check("out_valid_accum", out_valid, 0);
    endtask

    // One beat with optional leading idle cycles; beat index idx of a job with R rows.
    task automatic do_beat(input int idx, input int R, input logic [VW-1:0] v, input bit gaps);
        if (gaps) begin
            repeat (2) begin
                @(negedge clk);
                psum_valid = 1'b0;
                psum_vec   = rand_vec();
                #1;
                check("gap_wr_en", acc_wr_en, 0);
                check("gap_psum_ready", psum_ready, 1);
            end
        end
        @(negedge clk);
        psum_valid = 1'b1;
        psum_vec   = v;
        #1;
        check("beat_wr_en", acc_wr_en, 1);
        check("beat_mode", acc_mode, (idx >= R) ? 1 : 0);
        check("beat_addr", acc_addr, idx % R);
        check("beat_data", acc_psum_vec, v);
        if (idx < R) check("prior_row", acc_rd_vec, exp_bank[idx % R]);
        @(posedge clk);
    endtask

    task automatic run_job(input int rows_cmd, input int k_cmd, input bit gaps, input bit stall);
        int R;
        int K;
        logic [VW-1:0] sums [DEPTH];
        logic [VW-1:0] v;
        R = (rows_cmd == 0 || rows_cmd > DEPTH) ? DEPTH : rows_cmd;
        K = (k_cmd == 0) ? 1 : k_cmd;
        issue_cmd(rows_cmd, k_cmd);
        for (int i = 0; i < R * K; i++) begin
            v = (beats.size() > 0) ? beats.pop_front() : rand_vec();
            sums[i % R] = (i < R) ? v : add_cols(sums[i % R], v);
            do_beat(i, R, v, gaps);
        end
        @(negedge clk);
        psum_valid = 1'b0;
        for (int r = 0; r < R; r++) begin
            if (stall) begin
                out_ready = 1'b0;
                #1;
                check("stall_valid", out_valid, 1);
                check("stall_vec", out_vec, sums[r]);
                check("stall_last", out_last, (r == R - 1) ? 1 : 0);
                check("stall_wr_en", acc_wr_en, 0);
                @(negedge clk);
            end
            out_ready = 1'b1;
            #1;
            check("drain_valid", out_valid, 1);
            check("drain_addr", acc_addr, r);
            check("drain_vec", out_vec, sums[r]);
            check("drain_last", out_last, (r == R - 1) ? 1 : 0);
            check("drain_wr_en", acc_wr_en, CLEAR);
            check("drain_psum_ready", psum_ready, 0);
            if (CLEAR) check("drain_clear_data", acc_psum_vec, 0);
            @(negedge clk);
        end
        out_ready = 1'b0;
        #1;
        check("done_pulse", done, 1);
        check("done_cmd_ready", cmd_ready, 1);
        check("done_busy", busy, 0);
        check("done_out_valid", out_valid, 0);
        @(negedge clk);
        #1;
        check("done_once", done, 0);
        for (int r = 0; r < R; r++) exp_bank[r] = CLEAR ? '0 : sums[r];
    endtask

    initial begin
        logic [VW-1:0] v;
        rst = 1'b1;
        cmd_valid = 1'b0; cmd_rows = '0; cmd_ktiles = '0;
        psum_valid = 1'b0; psum_vec = '0; out_ready = 1'b0;
        @(posedge clk);
        #1;
        check_reset_outputs();
        @(negedge clk);
        rst = 1'b0;

        $display("[TB] single K-tile");
        beats.push_back(splat(100));
        beats.push_back(splat(200));
        run_job(2, 1, 1'b0, 1'b0);

        $display("[TB] accumulate");
        beats.push_back(splat(100));
        beats.push_back(splat(50));
        beats.push_back(splat(25));
        run_job(1, 3, 1'b0, 1'b0);
        check("accum_175", exp_bank[0], CLEAR ? splat(0) : splat(175));

        $display("[TB] backpressure");
        run_job(4, 2, 1'b1, 1'b1);

        $display("[TB] clamping");
        run_job(0, 0, 1'b0, 1'b0);
        run_job(20, 1, 1'b0, 1'b1);

        $display("[TB] reset mid-ACCUM");
        issue_cmd(4, 2);
        for (int i = 0; i < 3; i++) begin
            v = rand_vec();
            do_beat(i, 4, v, 1'b0);
            exp_bank[i] = v;
        end
        @(negedge clk);
        psum_valid = 1'b0;
        rst = 1'b1;
        @(posedge clk);
        #1;
        check_reset_outputs();
        @(negedge clk);
        rst = 1'b0;
        beats.push_back(splat(7));
        run_job(1, 1, 1'b0, 1'b0);

        $display("[TB] prior-row visibility");
        run_job(2, 1, 1'b0, 1'b0);
        run_job(3, 2, 1'b1, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
